// File: rtl/proc_pkg.sv
// Types and address-map constants shared between the processor and its data-side memory controller.
package proc_pkg;

    localparam int WORD_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic [WORD_SIZE-1:0] LED_ADDR = 16'h1000;
    localparam logic [WORD_SIZE-1:0] SW_ADDR  = 16'h3000;

endpackage

// File: rtl/data_ram.sv
// Single-port on-chip RAM with a one-cycle registered read and write-first behaviour.
// Contents are deliberately not reset.
module data_ram #(
    parameter int WORDS = 4096,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: multi-cycle RAM accesses with a stall handshake,
// zero-wait LED/switch MMIO, and a sticky protocol/decode error flag.
//   state | meaning
//   IDLE  | accept a request; MMIO/unmapped accesses complete here
//   BUSY  | RAM access in flight, counting down the extra latency
//   RESP  | RAM access done, stall released for exactly one cycle
module data_mem_ctrl
    import proc_pkg::*;
#(
    parameter int RAM_WORDS   = 4096,
    parameter int RAM_LATENCY = 2,
    parameter int LED_BITS    = 10,
    parameter int SW_BITS     = 10
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataWaitreq,
    output logic [LED_BITS-1:0]  LEDR,
    input  logic [SW_BITS-1:0]   SW,
    output logic                 ProtoErr
);

    localparam int                 AW        = $clog2(RAM_WORDS);
    localparam logic [3:0]         CNT_LOAD  = 4'(RAM_LATENCY - 1);
    localparam logic [WORD_SIZE:0] RAM_LIMIT = (WORD_SIZE + 1)'(RAM_WORDS);

    mem_state_t           state, state_nx;
    logic [3:0]           cnt;
    logic [AW-1:0]        lat_addr, ram_addr;
    logic                 lat_write, aborted;
    logic [WORD_SIZE-1:0] din_q, ram_rdata, mmio_rdata;
    logic [LED_BITS-1:0]  led_q;
    logic [SW_BITS-1:0]   sw_meta, sw_sync;
    logic                 req, is_ram, is_led, is_sw, start, ram_en, ram_we;

    assign req    = ReadData | WriteData;
    assign is_ram = {1'b0, DataAddr} < RAM_LIMIT;
    assign is_led = DataAddr == LED_ADDR;
    assign is_sw  = DataAddr == SW_ADDR;
    assign start  = (state == IDLE) && req && is_ram;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = BUSY;
            BUSY:    if (cnt == 4'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // BUSY keeps re-reading the latched address so the RAM output stays valid.
    always_comb begin
        DataWaitreq = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = lat_addr;
        case (state)
            IDLE: if (start) begin
                DataWaitreq = 1'b1;
                ram_en      = 1'b1;
                ram_we      = WriteData;
                ram_addr    = DataAddr[AW-1:0];
            end
            BUSY: begin
                DataWaitreq = 1'b1;
                ram_en      = 1'b1;
            end
            default: ;
        endcase
    end

    data_ram #(.WORDS(RAM_WORDS), .WIDTH(WORD_SIZE)) u_ram (
        .clk   (Clock),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (DataOut),
        .rdata (ram_rdata)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt       <= 4'd0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            aborted   <= 1'b0;
            din_q     <= '0;
            led_q     <= '0;
            ProtoErr  <= 1'b0;
            sw_meta   <= '0;
            sw_sync   <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
            if (start) begin
                cnt       <= CNT_LOAD;
                lat_addr  <= DataAddr[AW-1:0];
                lat_write <= WriteData;
                aborted   <= 1'b0;
            end
            if (state == BUSY) begin
                if (cnt != 4'd0) cnt <= cnt - 4'd1;
                if (!req) aborted <= 1'b1;
                if (cnt == 4'd0 && !lat_write && !aborted && req) din_q <= ram_rdata;
            end
            if (state == IDLE && WriteData && is_led) led_q <= DataOut[LED_BITS-1:0];
            if ((state == IDLE && req && (!(is_ram || is_led || is_sw) || (ReadData && WriteData)))
                || (state == BUSY && !req))
                ProtoErr <= 1'b1;
        end
    end

    always_comb begin
        mmio_rdata = '0;
        if (is_led)     mmio_rdata = WORD_SIZE'(led_q);
        else if (is_sw) mmio_rdata = WORD_SIZE'(sw_sync);
    end

    assign DataIn = (state == IDLE && ReadData && !WriteData && !is_ram) ? mmio_rdata : din_q;
    assign LEDR   = led_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: transaction-level expectations plus a per-cycle output compare.
module tb_data_mem_ctrl;

    localparam int LAT = 2;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [15:0] DataAddr = '0, DataOut = '0, DataIn;
    logic        ReadData = 1'b0, WriteData = 1'b0, DataWaitreq, ProtoErr;
    logic [9:0]  LEDR, SW = '0;

    data_mem_ctrl #(.RAM_WORDS(4096), .RAM_LATENCY(LAT), .LED_BITS(10), .SW_BITS(10)) dut (
        .Clock(Clock), .Resetn(Resetn), .DataAddr(DataAddr), .DataOut(DataOut),
        .ReadData(ReadData), .WriteData(WriteData), .DataIn(DataIn),
        .DataWaitreq(DataWaitreq), .LEDR(LEDR), .SW(SW), .ProtoErr(ProtoErr)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Model: memory contents, LED register, error flag, last returned RAM data, expected outputs.
    logic [15:0] m_mem [int];
    logic [9:0]  m_led = '0;
    logic        m_perr = 1'b0, m_wait = 1'b0;
    logic [15:0] m_dinreg = '0, m_din = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            check("cyc_waitreq", 32'(DataWaitreq), 32'(m_wait));
            check("cyc_datain",  32'(DataIn),      32'(m_din));
            check("cyc_ledr",    32'(LEDR),        32'(m_led));
            check("cyc_protoerr", 32'(ProtoErr),   32'(m_perr));
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic go_idle();
        ReadData = 1'b0; WriteData = 1'b0;
        m_wait = 1'b0; m_din = m_dinreg;
    endtask

    task automatic model_reset();
        m_led = '0; m_perr = 1'b0; m_dinreg = '0; m_din = '0; m_wait = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        Resetn = 1'b0;
        ReadData = 1'b0; WriteData = 1'b0;
        model_reset();
        #20;
        @(negedge Clock);
        Resetn = 1'b1;
        step();
        chk_en = 1'b1;
    endtask

    // One RAM access: LAT+1 stall cycles, then one RESP cycle.
    task automatic ram_op(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rdat, output int nwait);
        ReadData = rd; WriteData = wr; DataAddr = a; DataOut = d;
        m_wait = 1'b1; m_din = m_dinreg;
        if (wr) m_mem[int'(a)] = d;
        nwait = 0;
        for (int i = 0; i < LAT + 1; i++) begin
            #1;
            if (DataWaitreq) nwait++;
            step();
            if (i == 0 && rd && wr) m_perr = 1'b1;
        end
        m_wait = 1'b0;
        if (!wr) m_dinreg = m_mem[int'(a)];
        m_din = m_dinreg;
        #1;
        rdat = DataIn;
        if (DataWaitreq) nwait++;
        step();
        go_idle();
    endtask

    // One zero-wait access to a non-RAM address.
    task automatic mmio_op(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                           output logic [15:0] rdat);
        ReadData = rd; WriteData = wr; DataAddr = a; DataOut = d;
        m_wait = 1'b0;
        if (rd && !wr)
            m_din = (a == 16'h1000) ? {6'b0, m_led} : (a == 16'h3000) ? {6'b0, SW} : 16'h0000;
        else
            m_din = m_dinreg;
        #1;
        rdat = DataIn;
        step();
        if (wr && a == 16'h1000) m_led = d[9:0];
        if ((a != 16'h1000 && a != 16'h3000) || (rd && wr)) m_perr = 1'b1;
        go_idle();
    endtask

    logic [15:0] rdat;
    int nwait;

    initial begin
        #12;
        check("reset_datain",   32'(DataIn), 32'h0);
        check("reset_ledr",     32'(LEDR), 32'h0);
        check("reset_protoerr", 32'(ProtoErr), 32'h0);
        check("reset_waitreq",  32'(DataWaitreq), 32'h0);
        do_reset();

        ram_op(1'b0, 1'b1, 16'h0005, 16'hBEEF, rdat, nwait);
        check("wr_beef_waits", 32'(nwait), 32'd3);
        ram_op(1'b0, 1'b1, 16'h0006, 16'h1234, rdat, nwait);
        ram_op(1'b1, 1'b0, 16'h0005, 16'h0000, rdat, nwait);
        check("rd5_data", 32'(rdat), 32'hBEEF);
        check("rd5_waits", 32'(nwait), 32'd3);
        ram_op(1'b1, 1'b0, 16'h0006, 16'h0000, rdat, nwait);
        check("rd6_data", 32'(rdat), 32'h1234);
        check("rd6_waits", 32'(nwait), 32'd3);

        mmio_op(1'b0, 1'b1, 16'h1000, 16'hFFFF, rdat);
        check("led_after_wr", 32'(LEDR), 32'h3FF);
        mmio_op(1'b1, 1'b0, 16'h1000, 16'h0000, rdat);
        check("led_rd", 32'(rdat), 32'h03FF);

        SW = 10'h155;
        step(); step();
        mmio_op(1'b1, 1'b0, 16'h3000, 16'h0000, rdat);
        check("sw_rd", 32'(rdat), 32'h0155);
        mmio_op(1'b0, 1'b1, 16'h3000, 16'hFFFF, rdat);
        check("sw_wr_no_err", 32'(ProtoErr), 32'h0);

        mmio_op(1'b1, 1'b0, 16'h2000, 16'h0000, rdat);
        check("unmapped_rd", 32'(rdat), 32'h0);
        check("unmapped_err", 32'(ProtoErr), 32'h1);
        step(); step();

        ram_op(1'b1, 1'b1, 16'h0007, 16'h00AA, rdat, nwait);
        ram_op(1'b1, 1'b0, 16'h0007, 16'h0000, rdat, nwait);
        check("both_hi_is_write", 32'(rdat), 32'h00AA);

        // Abandoned read: request dropped and address wobbled while BUSY.
        do_reset();
        ReadData = 1'b1; DataAddr = 16'h0005;
        m_wait = 1'b1; m_din = m_dinreg;
        step();
        ReadData = 1'b0; DataAddr = 16'h0123;
        step();
        m_perr = 1'b1;
        step();
        m_wait = 1'b0;
        #1;
        check("abort_datain", 32'(DataIn), 32'h0);
        check("abort_err", 32'(ProtoErr), 32'h1);
        check("abort_resp_wait", 32'(DataWaitreq), 32'h0);
        step();
        go_idle();
        ram_op(1'b1, 1'b0, 16'h0006, 16'h0000, rdat, nwait);
        check("post_abort_rd", 32'(rdat), 32'h1234);

        // Reset in the middle of a committed write.
        mmio_op(1'b0, 1'b1, 16'h1000, 16'h02A5, rdat);
        mmio_op(1'b1, 1'b0, 16'h2000, 16'h0000, rdat);
        ReadData = 1'b0; WriteData = 1'b1; DataAddr = 16'h0008; DataOut = 16'h5A5A;
        m_mem[8] = 16'h5A5A;
        m_wait = 1'b1; m_din = m_dinreg;
        step();
        #2;
        chk_en = 1'b0;
        Resetn = 1'b0; WriteData = 1'b0;
        #1;
        check("midrst_datain", 32'(DataIn), 32'h0);
        check("midrst_ledr", 32'(LEDR), 32'h0);
        check("midrst_err", 32'(ProtoErr), 32'h0);
        check("midrst_wait", 32'(DataWaitreq), 32'h0);
        model_reset();
        #10;
        @(negedge Clock);
        Resetn = 1'b1;
        step();
        chk_en = 1'b1;
        ram_op(1'b1, 1'b0, 16'h0008, 16'h0000, rdat, nwait);
        check("write_survives_rst", 32'(rdat), 32'h5A5A);
        ram_op(1'b1, 1'b0, 16'h0005, 16'h0000, rdat, nwait);
        check("ram_kept_rd5", 32'(rdat), 32'hBEEF);

        step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-side memory controller downstream of the processor's Memory stage. It serves one word-addressed read or write at a time from the processor's data port. The backing store is an on-chip RAM with a configurable access latency, plus a small memory-mapped I/O region. It drives DataWaitreq so the processor stalls its earlier stages until the access completes.

Parameters:
WORD_SIZE, 16, data and address width in bits
RAM_WORDS, 4096, RAM depth; RAM occupies addresses 0 .. RAM_WORDS-1
RAM_LATENCY, 2, extra wait cycles per RAM access; legal range 1..15
LED_BITS, 10, width of the LED output register
SW_BITS, 10, width of the switch input

Ports:
Clock  in  1  system clock; all state updates on the rising edge
Resetn  in  1  asynchronous, active-low reset
DataAddr  in  WORD_SIZE  word address from the Memory stage
DataOut  in  WORD_SIZE  write data from the processor
ReadData  in  1  read request
WriteData  in  1  write request
DataIn  out  WORD_SIZE  read data returned to the processor
DataWaitreq  out  1  high means the processor must hold the request and stall
LEDR  out  LED_BITS  LED register contents
SW  in  SW_BITS  asynchronous switch inputs
ProtoErr  out  1  sticky protocol or decode error flag

Behaviour:
- Reset (Resetn=0, asynchronous):
  - State IDLE, wait counter 0, DataIn 0, LEDR 0, ProtoErr 0, SW synchroniser flops 0.
  - RAM contents are not reset.
- Address map:
  - RAM at addresses below RAM_WORDS.
  - LED register at 0x1000 (read/write); the low LED_BITS bits are written, reads are zero-extended.
  - SW at 0x3000 (read-only; writes are ignored). SW passes through a 2-flop synchroniser.
  - Any other address is unmapped.
- Request: req = ReadData | WriteData. While DataWaitreq=1, the processor holds DataAddr, DataOut, ReadData and WriteData stable.
- FSM states: IDLE, BUSY, RESP.
  - IDLE, req to RAM:
    - DataWaitreq=1 combinationally in the same cycle.
    - At the edge: latch the address and read/write flag; commit any write to RAM at this edge; issue the RAM read; load counter = RAM_LATENCY-1; go to BUSY.
  - BUSY:
    - DataWaitreq=1.
    - Counter decrements each cycle; when counter==0, capture the RAM read data into DataIn and go to RESP.
  - RESP:
    - DataWaitreq=0 and DataIn holds the read data (unchanged after a write). The processor completes the access this cycle.
    - Next state is IDLE unconditionally. A new request is evaluated only from IDLE, so back-to-back requests see one RESP cycle each.
  - RAM timing: DataWaitreq is high for RAM_LATENCY+1 cycles and low in the RESP cycle. A read therefore completes at cycle RAM_LATENCY+1 after the request first appears.
- MMIO and unmapped accesses in IDLE:
  - DataWaitreq=0; zero-wait, single-cycle access with no state change.
  - DataIn is driven combinationally from the LED/SW mux in that cycle. Outside of MMIO reads and RESP, DataIn holds its last registered value.
  - LED writes take effect at the edge.
  - Unmapped access: reads return 0, writes are dropped, ProtoErr is set at the edge.
- Boundary conditions:
  - ReadData and WriteData both high: treated as a write; ProtoErr set.
  - req deasserted while in BUSY: the committed write stands; read data is discarded (DataIn not updated); the FSM still passes through RESP; ProtoErr set.
  - DataAddr changing while in BUSY: ignored, since the latched address is used.
  - Reset mid-BUSY: the FSM returns to IDLE; a write already committed persists; the pending read is lost.
  - ProtoErr clears only on reset.
- Widths: the RAM index is DataAddr[$clog2(RAM_WORDS)-1:0], decoded only after the range check. The counter is 4 bits.

Decomposition:
- proc_pkg (shared with the processor):
  - WORD_SIZE
  - mem_state_t enum {IDLE, BUSY, RESP}
  - address-map constants LED_ADDR=16'h1000 and SW_ADDR=16'h3000
- Sub-module data_ram:
  - single-port, registered read (one cycle), write-first, no reset, behavioural array of RAM_WORDS x WORD_SIZE.
  - The controller adds the remaining RAM_LATENCY-1 cycles.
- The SW synchroniser is inline.

Test Plan:
- Reset, then write 0xBEEF to address 0x0005 (RAM_LATENCY=2) -> DataWaitreq high for 3 cycles, low on the 4th; the next read of 0x0005 returns DataIn=0xBEEF in its RESP cycle.
- Back-to-back reads of 0x0005 then 0x0006 (preloaded 0x1234) -> each sees 3 wait cycles plus one RESP cycle; DataIn is 0xBEEF then 0x1234; no overlap.
- Write 0xFFFF to 0x1000 -> DataWaitreq stays 0 and LEDR=0x3FF after the edge; a read of 0x1000 returns 0x03FF in the same cycle.
- Set SW=0x155 and wait 2 cycles; read 0x3000 -> DataIn=0x0155 with no wait.
- Read 0x2000 -> DataIn=0, DataWaitreq=0, ProtoErr=1 and it stays 1. Next, assert ReadData and WriteData together to 0x0007 with DataOut=0x00AA -> treated as a write; a later read returns 0x00AA.
- Start a read and drop ReadData in BUSY -> DataIn unchanged, FSM returns to IDLE after RESP, ProtoErr=1. Assert Resetn=0 mid-BUSY -> all outputs are reset immediately, without waiting for a clock edge.
